rr_arbiter8: RTL and testbench

//  Round-robin arbiter sharing one datapath resource (ALU/memory port) among 8 requesters.

---
 rtl/rr_arbiter8_pkg.sv | 15 +
 rtl/rr_pick8.sv | 34 +++
 rtl/rr_arbiter8.sv | 81 ++++++++
 tb/tb_rr_arbiter8.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants for the 8-way round-robin arbiter:
// state encoding, requester count, index width, one-hot helper.
package rr_arbiter8_pkg;

    localparam int REQ_N = 8;
    localparam int IDX_W = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [REQ_N-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8 = {{(REQ_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotate the request vector by ptr and priority-encode the first set bit,
// giving the winner in search order ptr, ptr+1, ... ptr+7 (mod 8).
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [2*REQ_N-1:0] dbl;
    logic [REQ_N-1:0]   rot;
    logic [IDX_W-1:0]   idx;
    logic               hit;

    assign dbl = {req, req};
    assign rot = dbl[ptr +: REQ_N];

    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int j = 0; j < REQ_N; j++) begin
            if (rot[j] && !hit) begin
                idx = j[IDX_W-1:0];
                hit = 1'b1;
            end
        end
    end

    assign winner = ptr + idx;
    assign found  = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared datapath resource among 8 requesters;
// holds a grant until done, withdrawal or hold timeout, then rotates priority.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int N        = REQ_N,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         busy,
    output logic         any_req,
    output logic         timeout
);

    localparam int HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];

    logic             state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       winner;
    logic             found;
    logic             hold_req;
    logic             tmo_hit;
    logic             release_now;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    assign any_req     = found;
    assign busy        = state;
    assign hold_req    = req[gnt_id];
    assign tmo_hit     = (HOLD_MAX != 0) && (cnt == HOLD_LAST);
    assign release_now = done || !hold_req || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            ptr     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state  <= ST_GRANT;
                        gnt    <= onehot8(winner);
                        gnt_id <= winner;
                        cnt    <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state   <= ST_IDLE;
                        gnt     <= '0;
                        ptr     <= gnt_id + 3'd1;
                        // Timeout is only reported when nothing else ended the grant
                        timeout <= tmo_hit && !done && hold_req;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8.
// Expected grants are hand-derived from the round-robin rules.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       any_req;
    logic       timeout;

    int n_checks;
    int n_errors;

    rr_arbiter8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .any_req (any_req),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_grant(input int id);
        tick();
        chk("grant_gnt", 32'(gnt), 32'(8'h01 << id));
        chk("grant_id", 32'(gnt_id), 32'(id));
        chk("grant_busy", 32'(busy), 32'd1);
    endtask

    task automatic do_release();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(gnt_id), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // idle with no requests; done while idle is ignored
        for (int i = 0; i < 10; i++) begin
            done = (i == 4);
            tick();
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_tmo", 32'(timeout), 32'd0);
        end
        done = 1'b0;
        chk("idle_anyreq", 32'(any_req), 32'd0);

        // two requesters alternate: 0,7,0,7
        req = 8'h81;
        #1;
        chk("anyreq", 32'(any_req), 32'd1);
        do_grant(0);
        do_release();
        do_grant(7);
        do_release();
        do_grant(0);
        do_release();
        do_grant(7);
        do_release();
        req = 8'h00;

        // all request: 0..7 then wrap to 0
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            do_grant(i % 8);
            do_release();
        end
        req = 8'h00;

        // timeout after 16 held cycles, then regrant of 2
        req = 8'h04;
        do_grant(2);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("hold_gnt", 32'(gnt), 32'h04);
            chk("hold_tmo", 32'(timeout), 32'd0);
        end
        tick();
        chk("tmo_gnt", 32'(gnt), 32'd0);
        chk("tmo_pulse", 32'(timeout), 32'd1);
        do_grant(2);
        chk("tmo_clear", 32'(timeout), 32'd0);

        // done coincident with the timeout cycle: no pulse
        for (int k = 1; k < 16; k++) tick();
        chk("pre_gnt", 32'(gnt), 32'h04);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("both_gnt", 32'(gnt), 32'd0);
        chk("both_tmo", 32'(timeout), 32'd0);
        req = 8'h00;

        // holder 3 withdraws; 4 then wins before 3
        req = 8'h08;
        do_grant(3);
        tick();
        chk("hold3", 32'(gnt), 32'h08);
        req = 8'h10;
        tick();
        chk("withdraw_gnt", 32'(gnt), 32'd0);
        chk("withdraw_tmo", 32'(timeout), 32'd0);
        req = 8'h18;
        do_grant(4);
        req = 8'h19;
        tick();
        chk("nonholder", 32'(gnt), 32'h10);
        req = 8'h18;
        do_release();
        do_grant(3);
        do_release();
        req = 8'h00;

        // async reset mid-grant, then search restarts at 0
        req = 8'h20;
        do_grant(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_id", 32'(gnt_id), 32'd0);
        req = 8'h81;
        #10;
        rst_n = 1'b1;
        do_grant(0);
        req = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
